// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector, bubble encoding, IF/ID record and
// fetch state encoding reused by the later pipeline stages.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] IM_DEPTH = 32'd128;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc4: 32'h0000_0000, valid: 1'b0};

  // Word index relative to the reset vector; PCs below it wrap to huge values.
  function automatic logic [31:0] word_index(input logic [31:0] pc);
    return (pc - RESET_PC) >> 2'd2;
  endfunction

  function automatic logic pc_in_range(input logic [31:0] pc);
    return (word_index(pc) < IM_DEPTH);
  endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter register with next-PC priority mux (redirect > stall > +4)
// and the redirect-target alignment check.
module pc_reg
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        misaligned
);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;

  assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
  assign pc         = pc_r;

  // Next-PC selection; a misaligned target is refused and the PC holds.
  always_comb begin
    pc_next_s = pc_r;
    if (freeze) begin
      pc_next_s = pc_r;
    end else if (redirect) begin
      if (misaligned) begin
        pc_next_s = pc_r;
      end else begin
        pc_next_s = redirect_pc;
      end
    end else if (stall) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_r + 32'd4;
    end
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the fetched word into IF/ID; sticky fault on bad fetches.
module if_fetch
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault
);

  fetch_state_t state_r;
  ifid_t        ifid_r;
  logic         fetch_fault_r;
  logic         freeze_s;
  logic         misaligned_s;
  logic         out_of_range_s;
  logic         fault_s;
  logic [31:0]  pc_s;
  logic [31:0]  pc4_s;

  assign freeze_s = (state_r == ST_FAULT);

  pc_reg u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze_s),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc_s),
    .misaligned  (misaligned_s)
  );

  assign pc4_s          = pc_s + 32'd4;
  assign out_of_range_s = !pc_in_range(pc_s);
  // An out-of-range PC only faults when it would actually be fetched.
  assign fault_s        = misaligned_s || (out_of_range_s && !stall);

  assign im_addr     = pc_s[11:2];
  assign pc_o        = pc_s;
  assign ifid_instr  = ifid_r.instr;
  assign ifid_pc4    = ifid_r.pc4;
  assign ifid_valid  = ifid_r.valid;
  assign fetch_fault = fetch_fault_r;

  // Fault FSM with IF/ID register and sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_RUN;
      ifid_r        <= IFID_BUBBLE;
      fetch_fault_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (fault_s) begin
            state_r       <= ST_FAULT;
            ifid_r        <= IFID_BUBBLE;
            fetch_fault_r <= 1'b1;
          end else if (flush || redirect) begin
            ifid_r <= IFID_BUBBLE;
          end else if (!stall) begin
            ifid_r <= '{instr: im_dout, pc4: pc4_s, valid: 1'b1};
          end else begin
            ifid_r <= ifid_r;
          end
        end
        ST_FAULT: begin
          ifid_r        <= IFID_BUBBLE;
          fetch_fault_r <= 1'b1;
        end
        default: begin
          state_r       <= ST_FAULT;
          ifid_r        <= IFID_BUBBLE;
          fetch_fault_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed test-plan sequence with literal
// expectations, then randomized traffic against a behavioural model.
module tb_if_fetch;

  localparam logic [31:0] RST_VEC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic [31:0] pc_o;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_fault;

  logic [31:0] mem [0:1023];
  int n_tests = 0;
  int n_fail  = 0;

  assign im_dout = mem[im_addr];

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_addr     (im_addr),
    .im_dout     (im_dout),
    .pc_o        (pc_o),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_valid  (ifid_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC, IF/ID contents and the sticky fault flag.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_offset;
  logic        m_bad_target;
  logic        m_beyond;

  assign m_offset     = m_pc - RST_VEC;
  assign m_bad_target = redirect && ((redirect_pc % 4) != 0);
  assign m_beyond     = ((m_offset / 4) >= 128) && !stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RST_VEC; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0; m_fault <= 1'b0;
    end else if (m_fault) begin
      m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
    end else begin
      if (m_bad_target || m_beyond || flush || redirect) begin
        m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      end else if (!stall) begin
        m_instr <= mem[m_offset[11:2]];
        m_pc4   <= m_pc + 4;
        m_valid <= 1'b1;
      end
      if (redirect) begin
        if (!m_bad_target) m_pc <= redirect_pc;
      end else if (!stall) begin
        m_pc <= m_pc + 4;
      end
      if (m_bad_target || m_beyond) m_fault <= 1'b1;
    end
  end

  // Compare process: every falling edge, DUT against the model.
  always @(negedge clk) begin
    check("pc", pc_o, m_pc);
    check("im_addr", {22'd0, im_addr}, {22'd0, m_pc[11:2]});
    check("ifid_instr", ifid_instr, m_instr);
    check("ifid_pc4", ifid_pc4, m_pc4);
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'h0000_0000;
    mem[16] = 32'hDEAD_0010;
    mem[128] = 32'hBAD0_0080;

    #1 rst = 1'b1;
    tick(); tick();
    check("rst_pc", pc_o, 32'h3000);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    rst = 1'b0;

    tick();
    check("seq0_instr", ifid_instr, 32'h2008_0001);
    check("seq0_pc4", ifid_pc4, 32'h3004);
    check("seq0_valid", {31'd0, ifid_valid}, 32'd1);
    check("seq0_pc", pc_o, 32'h3004);
    tick();
    check("seq1_instr", ifid_instr, 32'h2009_0002);
    check("seq1_pc4", ifid_pc4, 32'h3008);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", pc_o, 32'h3008);
      check("stall_instr", ifid_instr, 32'h2009_0002);
      check("stall_pc4", ifid_pc4, 32'h3008);
    end
    stall = 1'b0;
    tick();
    check("unstall_instr", ifid_instr, 32'h0109_5020);
    check("unstall_pc4", ifid_pc4, 32'h300C);
    check("unstall_pc", pc_o, 32'h300C);

    redirect = 1'b1; redirect_pc = 32'h3040;
    tick();
    check("redir_instr", ifid_instr, 32'h0);
    check("redir_valid", {31'd0, ifid_valid}, 32'd0);
    check("redir_pc", pc_o, 32'h3040);
    redirect = 1'b0;
    tick();
    check("target_instr", ifid_instr, 32'hDEAD_0010);
    check("target_pc4", ifid_pc4, 32'h3044);

    redirect = 1'b1; redirect_pc = 32'h3020; stall = 1'b1; flush = 1'b1;
    tick();
    check("rsf_pc", pc_o, 32'h3020);
    check("rsf_valid", {31'd0, ifid_valid}, 32'd0);
    redirect = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    check("pre_mis_pc", pc_o, 32'h3028);

    redirect = 1'b1; redirect_pc = 32'h3022;
    tick();
    check("mis_fault", {31'd0, fetch_fault}, 32'd1);
    check("mis_pc", pc_o, 32'h3028);
    check("mis_valid", {31'd0, ifid_valid}, 32'd0);
    redirect_pc = 32'h3000;
    tick();
    check("fault_ignore_pc", pc_o, 32'h3028);
    check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    redirect = 1'b0; rst = 1'b1;
    tick();
    check("clear_fault", {31'd0, fetch_fault}, 32'd0);
    check("clear_pc", pc_o, 32'h3000);
    rst = 1'b0;

    for (int k = 0; k < 128; k++) tick();
    check("edge_pc", pc_o, 32'h3200);
    check("edge_instr", ifid_instr, mem[127]);
    check("edge_nofault", {31'd0, fetch_fault}, 32'd0);
    tick();
    check("oor_fault", {31'd0, fetch_fault}, 32'd1);
    check("oor_valid", {31'd0, ifid_valid}, 32'd0);
    check("oor_instr", ifid_instr, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_pc", pc_o, 32'h3000);
    check("async_fault", {31'd0, fetch_fault}, 32'd0);
    tick();
    rst = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      tick();
      rst      = ($urandom_range(0, 99) < 2);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      redirect = ($urandom_range(0, 5) == 0);
      redirect_pc = RST_VEC + 32'(4 * $urandom_range(0, 135));
      if ($urandom_range(0, 19) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 29) == 0) redirect_pc = 32'h2FF0;
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the pipelined MIPS core: the initiator side of the instruction-memory read interface. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. It supports:
- stall and flush from hazard control;
- branch/jump redirect from ID;
- a sticky fetch fault on misaligned or out-of-range fetches.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `IM_DEPTH`, 128, number of valid instruction words; fetch index must be < `IM_DEPTH`.
- `NOP`, 32'h0000_0000, bubble instruction inserted on flush/reset/fault.
- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID contents.
- `flush`  in  1  replace IF/ID contents with bubble.
- `redirect`  in  1  load `redirect_pc` into PC (taken branch, j, jal, jr).
- `redirect_pc`  in  32  redirect target byte address.
- `im_addr`  out  10  instruction memory word address, = pc[11:2].
- `im_dout`  in  32  instruction memory data; combinational function of `im_addr`.
- `pc_o`  out  32  current PC.
- `ifid_instr`  out  32  registered instruction.
- `ifid_pc4`  out  32  registered PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `fetch_fault`  out  1  sticky fault flag.

## Operation
- State machine: RUN, FAULT. Reset enters RUN.
- Reset values:
  - pc = `RESET_PC`; `ifid_instr` = `NOP`; `ifid_pc4` = 0; `ifid_valid` = 0; `fetch_fault` = 0.
- `im_addr` = pc[11:2] combinationally at all times, in both states.
- RUN, per rising edge, PC update in priority order:
  - `redirect` → `redirect_pc`;
  - else `stall` → hold;
  - else pc+4.
  - PC arithmetic is 32-bit and wraps modulo 2^32.
- RUN, IF/ID update in priority order:
  - `flush` or `redirect` → `NOP`, `ifid_pc4` = 0, `ifid_valid` = 0;
  - else `stall` → hold all three;
  - else `im_dout`, pc+4, 1.
- Redirect beats stall: a redirect during stall is never lost.
- Flush beats stall.
- Fault detection, in RUN:
  - `redirect` asserted with `redirect_pc[1:0]` ≠ 0 → next state FAULT; PC is not loaded.
  - Current pc word index, (pc − `RESET_PC`) >> 2, ≥ `IM_DEPTH` while not stalled → next state FAULT; IF/ID takes bubble instead of `im_dout`.
- FAULT:
  - PC frozen; IF/ID forced to bubble every cycle; `fetch_fault` = 1.
  - Ignores `stall`, `flush` and `redirect`.
  - Exit only via `rst`.
- `rst` asserted mid-operation clears all state immediately (asynchronous), regardless of state or pending redirect.

## Timing
- Memory read is zero-latency; fetch-to-IF/ID latency is exactly 1 cycle.
- First edge after `rst` deasserts:
  - IF/ID captures word 0, `ifid_pc4` = `RESET_PC`+4, `ifid_valid` = 1;
  - pc = `RESET_PC`+4.
- Redirect sampled at edge N:
  - pc = target after N;
  - the bubble is in IF/ID after N;
  - the target instruction is in IF/ID after edge N+1.
  - Penalty: one bubble.
- Stall held for k edges → PC and IF/ID unchanged for k edges; advance on first edge with `stall` = 0.
- `fetch_fault` rises on the same edge the FAULT transition occurs.
- No input is registered internally. `stall`, `flush` and `redirect` must be stable before the edge.

## Structure
- Shared CPU package (`cpu_defs`) holds:
  - `RESET_PC`;
  - the `NOP` encoding;
  - the IF/ID record fields (instr, pc4, valid);
  - the RUN/FAULT state encoding.
- The ID/EX stages reuse these definitions.
- One natural sub-module: `pc_reg`, holding the PC register plus next-PC priority mux and alignment check. `if_fetch` instantiates it alongside the IF/ID register and fault FSM.
- The instruction memory stays outside the block and is connected at the datapath top.

## Test plan
- **Reset and sequential fetch:** memory words 0..3 = 0x20080001, 0x20090002, 0x01095020, 0x00000000; release reset.
  - IF/ID shows these words in order, `ifid_pc4` = 0x3004, 0x3008, 0x300C, 0x3010.
  - `ifid_valid` = 1 from the first edge.
- **Stall:** assert `stall` for 3 cycles while IF/ID holds 0x20090002.
  - pc stays 0x3008; IF/ID unchanged.
  - 0x01095020 appears on the first unstalled edge.
- **Redirect:** redirect to 0x3040 at pc 0x300C.
  - Next IF/ID = `NOP` with `ifid_valid` = 0, pc = 0x3040.
  - Following edge captures word 16 with `ifid_pc4` = 0x3044.
- **Redirect with stall and flush:** redirect to 0x3020 with `stall` = 1 and `flush` = 1 in the same cycle.
  - pc = 0x3020; IF/ID is a bubble.
- **Misaligned redirect:** `redirect_pc` = 0x3022.
  - `fetch_fault` = 1 on that edge; pc holds previous value; `ifid_valid` stays 0 thereafter.
  - Later redirects are ignored; `rst` clears the fault.
- **Out-of-range fetch:** sequential run to pc = 0x3200 (index 128).
  - FAULT entered; word at index 128 is never captured.
  - Asynchronous `rst` pulse mid-cycle returns pc to 0x3000 immediately.
